// File: rtl/sa_sequencer.sv
// Control sequencer for the 4x4 systolic-array matmul datapath: walks the
// instruction memory and runs one clear/stream/write job per nonzero K entry.
module sa_sequencer #(
    parameter int N_INSTR = 8,
    parameter int IA_W    = 3,
    parameter int K_W     = 5,
    parameter int COL_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             busy,
    output logic             instr_rd_en,
    output logic [IA_W-1:0]  instr_addr,
    input  logic [K_W-1:0]   instr_data,
    output logic             sa_clr,
    output logic             in_rd_en,
    output logic [COL_W-1:0] in_col,
    output logic             in_pad,
    output logic             out_wr_en,
    output logic [IA_W-1:0]  out_slot,
    output logic [K_W-1:0]   cur_k
);

    // One extra bit so the offset can reach K+6 for the largest K.
    localparam int OFF_W = K_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_CLEAR, S_STREAM, S_WRITE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IA_W-1:0]   idx_q, idx_d;
    logic [COL_W-1:0]  col_base_q, col_base_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [K_W-1:0]    cur_k_q, cur_k_d;
    logic [OFF_W-1:0]  k_ext;
    logic [OFF_W-1:0]  last_off;

    logic              ap_done_q, ap_done_d;
    logic              busy_q, busy_d;
    logic              instr_rd_en_q, instr_rd_en_d;
    logic [IA_W-1:0]   instr_addr_q, instr_addr_d;
    logic              sa_clr_q, sa_clr_d;
    logic              in_rd_en_q, in_rd_en_d;
    logic [COL_W-1:0]  in_col_q, in_col_d;
    logic              in_pad_q, in_pad_d;
    logic              out_wr_en_q, out_wr_en_d;
    logic [IA_W-1:0]   out_slot_q, out_slot_d;

    assign k_ext    = {1'b0, cur_k_q};
    assign last_off = k_ext + OFF_W'(6);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            col_base_q    <= '0;
            off_q         <= '0;
            cur_k_q       <= '0;
            ap_done_q     <= 1'b0;
            busy_q        <= 1'b0;
            instr_rd_en_q <= 1'b0;
            instr_addr_q  <= '0;
            sa_clr_q      <= 1'b0;
            in_rd_en_q    <= 1'b0;
            in_col_q      <= '0;
            in_pad_q      <= 1'b0;
            out_wr_en_q   <= 1'b0;
            out_slot_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            col_base_q    <= col_base_d;
            off_q         <= off_d;
            cur_k_q       <= cur_k_d;
            ap_done_q     <= ap_done_d;
            busy_q        <= busy_d;
            instr_rd_en_q <= instr_rd_en_d;
            instr_addr_q  <= instr_addr_d;
            sa_clr_q      <= sa_clr_d;
            in_rd_en_q    <= in_rd_en_d;
            in_col_q      <= in_col_d;
            in_pad_q      <= in_pad_d;
            out_wr_en_q   <= out_wr_en_d;
            out_slot_q    <= out_slot_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        col_base_d = col_base_q;
        off_d      = off_q;
        cur_k_d    = cur_k_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (ap_start) begin
                    state_d    = S_FETCH;
                    idx_d      = '0;
                    col_base_d = '0;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                cur_k_d = instr_data;
                state_d = (instr_data == '0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: begin
                off_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (off_q == last_off) state_d = S_WRITE;
                else                   off_d   = off_q + 1'b1;
            end
            S_WRITE: begin
                col_base_d = col_base_q + COL_W'(cur_k_q);
                if (32'(idx_q) + 1 == N_INSTR) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes from a flop
    // that is aligned with the state it describes.
    always_comb begin
        ap_done_d     = (state_d == S_DONE);
        busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
        instr_rd_en_d = (state_d == S_FETCH);
        instr_addr_d  = (state_d == S_FETCH) ? idx_d : '0;
        sa_clr_d      = (state_d == S_CLEAR);
        in_rd_en_d    = (state_d == S_STREAM);
        in_pad_d      = 1'b0;
        in_col_d      = '0;
        if (state_d == S_STREAM) begin
            if (off_d < k_ext) begin
                in_col_d = col_base_q + COL_W'(off_d);
            end else begin
                in_col_d = in_col_q;
                in_pad_d = 1'b1;
            end
        end
        out_wr_en_d   = (state_d == S_WRITE);
        out_slot_d    = (state_d == S_WRITE) ? idx_d : '0;
    end

    assign ap_done     = ap_done_q;
    assign busy        = busy_q;
    assign instr_rd_en = instr_rd_en_q;
    assign instr_addr  = instr_addr_q;
    assign sa_clr      = sa_clr_q;
    assign in_rd_en    = in_rd_en_q;
    assign in_col      = in_col_q;
    assign in_pad      = in_pad_q;
    assign out_wr_en   = out_wr_en_q;
    assign out_slot    = out_slot_q;
    assign cur_k       = cur_k_q;

endmodule
